// File: rtl/coin_payer.sv
`default_nettype none
// ============================================================================
// Module   : coin_payer
// Purpose  : Customer-side stimulus master for the coffee vending FSM. It
//            accepts a cup order, then pays for each cup with the coin
//            sequence 10c, gap, 5c. It waits for the machine's coffee
//            indication before paying for the next cup, and counts the
//            cups that were delivered.
// Ports    : clk     - system clock, rising edge
//            reset   - asynchronous, active-low reset
//            start   - order strobe, sampled only in IDLE
//            cups    - cups to buy, sampled together with start
//            coffee  - delivery indication from the vending FSM
//            coins   - coin code: 00 none, 01 10c, 10 5c (11 never driven)
//            busy    - order in progress
//            done    - one-cycle pulse at order completion or abort
//            served  - cups confirmed in the current or last order
//            error   - sticky delivery-timeout flag
// Config   : COIN_PAYER_TIMEOUT_EN - when defined, a 3-bit watchdog aborts
//            the order if coffee is not seen within 4 WAIT cycles. When it
//            is undefined, WAIT waits forever and error is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module coin_payer #(
  parameter int CUPS_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CUPS_W-1:0] cups,
  input  logic              coffee,
  output logic [1:0]        coins,
  output logic              busy,
  output logic              done,
  output logic [CUPS_W-1:0] served,
  output logic              error
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    COIN10 = 3'd1,
    GAP    = 3'd2,
    COIN5  = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_10   = 2'b01;
  localparam logic [1:0] COIN_5    = 2'b10;

  state_t            state, state_nx;
  logic [CUPS_W-1:0] remaining, remaining_nx;
  logic [CUPS_W-1:0] served_nx;
  logic [1:0]        coins_nx;
  logic              busy_nx;
  logic              done_nx;

`ifdef COIN_PAYER_TIMEOUT_EN
  logic [2:0] wd, wd_nx;
  logic       error_r, error_nx;
`endif

  // State and registered outputs. The outputs are loaded from the decode of
  // the next state so that they line up with the state they describe while
  // still coming straight from flops; the async reset clears coins at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      remaining <= '0;
      served    <= '0;
      coins     <= COIN_NONE;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef COIN_PAYER_TIMEOUT_EN
      wd        <= 3'd0;
      error_r   <= 1'b0;
`endif
    end else begin
      state     <= state_nx;
      remaining <= remaining_nx;
      served    <= served_nx;
      coins     <= coins_nx;
      busy      <= busy_nx;
      done      <= done_nx;
`ifdef COIN_PAYER_TIMEOUT_EN
      wd        <= wd_nx;
      error_r   <= error_nx;
`endif
    end
  end

  always_comb begin
    state_nx     = state;
    remaining_nx = remaining;
    served_nx    = served;
`ifdef COIN_PAYER_TIMEOUT_EN
    wd_nx        = wd;
    error_nx     = error_r;
`endif

    case (state)
      IDLE: begin
        if (start) begin
          // Any accepted order starts with a clean slate, including a
          // zero-cup order, so served/error always describe the last order.
          served_nx = '0;
`ifdef COIN_PAYER_TIMEOUT_EN
          error_nx  = 1'b0;
`endif
          if (cups != '0) begin
            remaining_nx = cups;
            state_nx     = COIN10;
          end else begin
            state_nx = DONE;
          end
        end
      end
      COIN10: state_nx = GAP;
      GAP:    state_nx = COIN5;
      COIN5: begin
        state_nx = WAIT;
`ifdef COIN_PAYER_TIMEOUT_EN
        wd_nx    = 3'd0;
`endif
      end
      WAIT: begin
        if (coffee) begin
          served_nx    = (served == '1) ? served : served + 1'b1;
          remaining_nx = remaining - 1'b1;
          state_nx     = (remaining == 1) ? DONE : COIN10;
        end
`ifdef COIN_PAYER_TIMEOUT_EN
        // wd holds the number of WAIT cycles already spent without coffee;
        // the fourth empty cycle aborts the order.
        else if (wd == 3'd3) begin
          error_nx = 1'b1;
          state_nx = DONE;
        end else begin
          wd_nx = wd + 3'd1;
        end
`endif
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase

    case (state_nx)
      COIN10:  coins_nx = COIN_10;
      COIN5:   coins_nx = COIN_5;
      default: coins_nx = COIN_NONE;
    endcase
    busy_nx = (state_nx == COIN10) || (state_nx == GAP) ||
              (state_nx == COIN5)  || (state_nx == WAIT);
    done_nx = (state_nx == DONE);
  end

`ifdef COIN_PAYER_TIMEOUT_EN
  assign error = error_r;
`else
  assign error = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_coin_payer.sv
`default_nettype none
// ============================================================================
// Module   : tb_coin_payer
// Purpose  : Self-checking bench for coin_payer. A cycle-level order model
//            (cups left, cycle offset within the current cup) predicts every
//            output each cycle; the bench also plays the vending machine by
//            raising coffee a chosen number of WAIT cycles after payment,
//            and injects spurious coffee outside WAIT. Directed orders pin
//            the model with hand-computed cycle counts.
// Revision : 1.0 - initial release
// ============================================================================
module tb_coin_payer;

`ifdef COIN_PAYER_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif
  localparam int MAXS = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic [3:0] cups = 4'd0;
  logic       coffee = 1'b0;
  logic [1:0] coins;
  logic       busy, done, error;
  logic [3:0] served;

  coin_payer #(.CUPS_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .cups(cups), .coffee(coffee),
    .coins(coins), .busy(busy), .done(done), .served(served), .error(error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Order model: an order is "active" while coins are being paid or coffee
  // awaited; t counts cycles since the current cup's 10c coin (t>=3 = waiting).
  bit active   = 1'b0;
  int left_m   = 0;
  int t        = 0;
  int served_m = 0;
  bit err_m    = 1'b0;
  bit done_m   = 1'b0;

  int delay_mode = 0;   // 0 prompt, 1 random 0..6, 2 fixed 10, 3 never
  int cur_delay  = 0;
  bit noise_en   = 1'b0;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int pick_delay();
    case (delay_mode)
      0:       return 0;
      1:       return int'($urandom_range(6));
      2:       return 10;
      default: return 1000000;
    endcase
  endfunction

  function automatic int exp_coins();
    if (active && t == 0) return 1;
    if (active && t == 2) return 2;
    return 0;
  endfunction

  task automatic model_update();
    bit dn;
    dn = 1'b0;
    if (active) begin
      if (t >= 3) begin
        if (coffee) begin
          if (served_m < MAXS) served_m++;
          left_m--;
          if (left_m == 0) begin
            active = 1'b0;
            dn = 1'b1;
          end else begin
            t = 0;
            cur_delay = pick_delay();
          end
        end else if (TMO && (t - 3) == 3) begin
          err_m  = 1'b1;
          active = 1'b0;
          dn     = 1'b1;
        end else begin
          t++;
        end
      end else begin
        t++;
      end
    end else if (!done_m && start) begin
      served_m = 0;
      err_m    = 1'b0;
      if (cups != 0) begin
        active    = 1'b1;
        left_m    = int'(cups);
        t         = 0;
        cur_delay = pick_delay();
      end else begin
        dn = 1'b1;
      end
    end
    done_m = dn;
  endtask

  // One clock cycle: drive inputs for the coming edge, advance the model at
  // the edge, and return shortly after it so outputs have settled.
  task automatic step(input bit s, input logic [3:0] c);
    start = s;
    cups  = c;
    if (active && t >= 3)
      coffee = ((t - 3) >= cur_delay);
    else
      coffee = noise_en ? ($urandom_range(3) == 0) : 1'b0;
    @(posedge clk);
    model_update();
    #2;
  endtask

  // Per-cycle comparison of all outputs against the model, plus the
  // coin-bus legality rules (no 11, never two non-zero codes in a row).
  int prev_coins = 0;
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("coins", int'(coins), exp_coins());
      chk("busy", int'(busy), int'(active));
      chk("done", int'(done), int'(done_m));
      chk("served", int'(served), served_m);
      chk("error", int'(error), int'(err_m));
      chk("coins_legal", int'(coins != 2'b11), 1);
      if (prev_coins != 0) chk("coins_gap", int'(coins == 2'b00), 1);
      prev_coins = int'(coins);
    end else begin
      prev_coins = 0;
    end
  end

  int seq [1:16];

  // Runs one order from the accepting edge; n_done is the cycle offset
  // (edge k = 0) in which done is seen, -1 if never.
  task automatic order(input int c, input bit poke, output int n_done, output int n_busy);
    logic [3:0] cv;
    cv = c[3:0];
    n_done = -1;
    n_busy = 0;
    step(1'b1, cv);
    for (int n = 1; n <= 300; n++) begin
      if (n <= 16) seq[n] = int'(coins);
      if (busy) n_busy++;
      if (done) begin
        n_done = n;
        break;
      end
      step(poke && (n == 2 || n == 5), 4'd3);
    end
  endtask

  int nd, nb;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_coins", int'(coins), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_served", int'(served), 0);
    chk("rst_error", int'(error), 0);
    @(negedge clk);
    reset  = 1'b1;
    chk_en = 1'b1;
    step(1'b0, 4'd0);

    // Single cup, prompt delivery: 01,00,10,00 then done at k+5
    delay_mode = 0;
    order(1, 1'b0, nd, nb);
    chk("c1_seq1", seq[1], 1);
    chk("c1_seq2", seq[2], 0);
    chk("c1_seq3", seq[3], 2);
    chk("c1_seq4", seq[4], 0);
    chk("c1_done_at", nd, 5);
    chk("c1_busy_cycles", nb, 4);
    chk("c1_served", int'(served), 1);
    // start coinciding with done is ignored
    step(1'b1, 4'd1);
    chk("done_start_ignored", int'(busy), 0);
    step(1'b0, 4'd0);

    // Three cups, prompt delivery
    order(3, 1'b0, nd, nb);
    chk("c3_done_at", nd, 13);
    chk("c3_busy_cycles", nb, 12);
    chk("c3_served", int'(served), 3);
    step(1'b0, 4'd0);

    // Zero-cup order: done next cycle, no coins
    order(0, 1'b0, nd, nb);
    chk("c0_done_at", nd, 1);
    chk("c0_coins", seq[1], 0);
    step(1'b0, 4'd0);

    // Start pulses during a 2-cup order are ignored
    order(2, 1'b1, nd, nb);
    chk("c2poke_done_at", nd, 9);
    chk("c2poke_served", int'(served), 2);
    step(1'b0, 4'd0);

`ifdef COIN_PAYER_TIMEOUT_EN
    // Timeout: coffee never comes
    delay_mode = 3;
    order(2, 1'b0, nd, nb);
    chk("tmo_done_at", nd, 8);
    chk("tmo_error", int'(error), 1);
    chk("tmo_served", int'(served), 0);
    step(1'b0, 4'd0);
    delay_mode = 0;
    step(1'b1, 4'd1);
    chk("tmo_error_cleared", int'(error), 0);
    for (int i = 0; i < 8; i++) step(1'b0, 4'd0);
`else
    // Late delivery: coffee 10 cycles into WAIT is still counted
    delay_mode = 2;
    order(1, 1'b0, nd, nb);
    chk("late_done_at", nd, 15);
    chk("late_served", int'(served), 1);
    chk("late_error", int'(error), 0);
    step(1'b0, 4'd0);
    delay_mode = 0;
`endif

    // Reset mid-COIN10
    step(1'b1, 4'd3);
    chk("pre_rst_coins", int'(coins), 1);
    chk_en = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_coins", int'(coins), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_served", int'(served), 0);
    @(posedge clk);
    #1;
    chk("mid_rst_done", int'(done), 0);
    active = 1'b0; done_m = 1'b0; served_m = 0; err_m = 1'b0; t = 0; left_m = 0;
    @(negedge clk);
    reset  = 1'b1;
    chk_en = 1'b1;
    step(1'b0, 4'd0);
    step(1'b0, 4'd0);
    chk("post_rst_idle", int'(busy), 0);

    // Randomized orders with random delivery delays and coffee noise
    delay_mode = 1;
    noise_en   = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] c;
      c = ($urandom_range(15) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(4));
      step($urandom_range(3) == 0, c);
    end
    noise_en = 1'b0;
    for (int i = 0; i < 200 && (active || done_m); i++) step(1'b0, 4'd0);
    chk("drain_idle", int'(active || done_m), 0);
    step(1'b0, 4'd0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/coin_payer.md
# coin_payer

Customer-side stimulus master for the coffee vending FSM: accepts a cup order, then drives the vending machine's 2-bit `coins` bus one coin at a time: 10 cent, gap, 5 cent per cup, at 15 cents a cup. It watches the machine's `coffee` output to confirm each delivery and counts served cups. It flags an error when the machine fails to deliver. It sits opposite the vending FSM, on the same `coins`/`coffee` interface, in system-level benches and demo top-levels.

## Interface
- `CUPS_W`, default 4: width of the cup-order and served-count buses.
- `clk`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low.
- `start`  in  1  order strobe; sampled only in IDLE.
- `cups`  in  CUPS_W  number of cups to buy, sampled with `start`.
- `coffee`  in  1  delivery indication from the vending FSM.
- `coins`  out  2  coin code: 00 none, 01 = 10 cent, 10 = 5 cent; 11 is never driven.
- `busy`  out  1  high from the cycle after an accepted `start` until DONE.
- `done`  out  1  one-cycle pulse when an order finishes or aborts.
- `served`  out  CUPS_W  cups confirmed in the current or last order.
- `error`  out  1  sticky delivery-timeout flag (see Configuration).

## Operation
- All outputs are registered. Reset values: `coins`=00, `busy`=0, `done`=0, `served`=0, `error`=0, state IDLE.
- States: IDLE, COIN10, GAP, COIN5, WAIT, DONE.
- IDLE → COIN10: on `start`=1 with `cups`≠0.
  - Latches `cups` into the remaining counter.
  - Clears `served` and `error`.
- IDLE → DONE: on `start`=1 with `cups`=0. No coins are driven.
- COIN10: `coins`=01 for exactly one cycle, then → GAP.
- GAP: `coins`=00 for one cycle, then → COIN5. The gap guarantees that no held code is ever counted twice.
- COIN5: `coins`=10 for one cycle, then → WAIT.
- WAIT: `coins`=00.
  - `coffee`=1 increments `served` and decrements remaining.
  - If remaining reaches 0 → DONE; otherwise → COIN10.
- DONE: `done`=1 for one cycle, `busy`=0, then → IDLE.
- `coffee` is ignored outside WAIT.
- `start` is ignored while `busy`=1.
- `served` saturates at all-ones and never wraps.
- Reset asserted mid-order:
  - Immediate return to IDLE.
  - `coins`=00 asynchronously.
  - No `done` pulse.

## Timing
- Accepted `start` at edge k: COIN10 occupies cycle k+1, GAP k+2, COIN5 k+3, WAIT from k+4.
- Against the Moore vending FSM, `coffee` rises in the first WAIT cycle. Minimum cost is 4 cycles per cup.
- An N-cup order with prompt delivery drives `done` in cycle k+4N+1. `busy` is high for cycles k+1 … k+4N.
- WAIT always drives 00, which returns the vending FSM to its zero-credit state before the next COIN10.
- `start` seen in the same cycle as `done` is ignored. It is accepted from the following IDLE cycle.

## Configuration
- `COIN_PAYER_TIMEOUT_EN` defined: a 3-bit watchdog counts WAIT cycles.
  - If `coffee` is not seen within 4 consecutive WAIT cycles, `error` is set and → DONE with a `done` pulse.
  - `served` holds the partial count.
  - `error` stays set until the next accepted `start` or reset.
- Macro undefined:
  - WAIT waits indefinitely for `coffee`.
  - `error` is tied to 0 and the watchdog is not built.

## Test plan
- Reset: `reset`=0 mid-COIN10 → `coins`=00 immediately, `busy`=0, `served`=0, no `done`. After release, the block idles.
- Single cup against the vending FSM model: `start`, `cups`=1 → `coins` sequence 01,00,10,00. Then `coffee`=1 in cycle k+4, `served`=1, `done` in cycle k+5.
- Three cups, prompt delivery: `cups`=3 → 12 busy cycles, `served`=3, `done` in cycle k+13. No 11 code and no back-to-back non-zero codes appear.
- Zero order / busy start: `cups`=0 → `done` next cycle with no coins. A `start` pulse during a 2-cup order leaves the sequence and `served`=2 unchanged.
- Timeout with macro defined: `coffee` held 0, `cups`=2 → after 4 WAIT cycles `error`=1, `served`=0, `done` pulses. The next `start` clears `error`.
- Late delivery with macro undefined: `coffee` delayed 10 cycles in WAIT → still counted, `error`=0, order completes.
